// File: rtl/pe2_bfly_param_pkg.sv
// pe2_bfly_param_pkg: shared defaults, phase enums and sizing helper for the radix-2 butterfly PE.
package pe2_bfly_param_pkg;
    localparam int DW_DEF      = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int SCALE_W_DEF = 2;
    typedef enum logic {PH_UP = 1'b0, PH_DOWN = 1'b1} in_phase_e;
    typedef enum logic {PH_SUM = 1'b0, PH_DIFF = 1'b1} out_phase_e;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/pe2_bfly_param_if.sv
// pe2_bfly_param_if: input and output sample streams with valid/ready handshakes.
interface pe2_bfly_param_if
    import pe2_bfly_param_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im
    );
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im
    );
endinterface

// File: rtl/pe2_bfly_param_pair_fifo.sv
// pe2_pair_fifo: synchronous FIFO of result pairs with the head visible combinationally.
module pe2_pair_fifo
    import pe2_bfly_param_pkg::*;
#(
    parameter type T     = logic,
    parameter int  DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       data_i,
    output T                       head_o,
    output logic [clog2(DEPTH):0]  count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = clog2(DEPTH);
    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]    count_q, count_d;
    logic           do_pop;
    always_comb begin
        full_o  = count_q == (AW+1)'(DEPTH);
        empty_o = count_q == '0;
        do_pop  = pop_i && !empty_o;
        wr_d    = push_i ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        head_o  = mem_q[rd_q];
        count_o = count_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/pe2_bfly_param.sv
// pe2_bfly_param: radix-2 butterfly PE pairing samples, scaling results and streaming them sum-first.
// Define PE2_ROUND_EN to round half up before the scaling shift instead of flooring.
module pe2_bfly_param
    import pe2_bfly_param_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int SCALE_W = SCALE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               select_i,
    input  logic [SCALE_W-1:0] scaling_i,
    output logic               ovf_o,
    pe2_bfly_param_if.slave    bus
);
    localparam int CW = clog2(DEPTH) + 1;
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } sample_t;
    typedef struct packed {
        sample_t sum;
        sample_t diff;
    } pair_t;
    typedef struct packed {
        logic signed [DW:0] re;
        logic signed [DW:0] im;
    } wide_t;

    in_phase_e          in_phase_q, in_phase_d;
    out_phase_e         out_phase_q, out_phase_d;
    sample_t            up_q, up_d;
    wide_t              sum_q, sum_d, diff_q, diff_d;
    logic               bfly_v_q, bfly_v_d;
    logic [SCALE_W-1:0] scl_q, scl_d;
    logic               ovf_q, ovf_d;
    pair_t              push_data, head;
    sample_t            head_w;
    logic [CW-1:0]      count;
    logic [3:0]         ov;
    logic               full, empty, push, pop, in_rdy, acc_in, acc_out;

    // Result is {overflow, value}; DW+2 bits keep the rounding add from wrapping.
    function automatic logic [DW:0] scale(input logic signed [DW:0] v, input logic [SCALE_W-1:0] s);
        logic signed [DW+1:0] x;
        x = {v[DW], v};
`ifdef PE2_ROUND_EN
        if (s != '0) x = x + ((DW+2)'(1) << (s - SCALE_W'(1)));
`endif
        x = x >>> s;
        return {!(x[DW+1:DW-1] == '0 || x[DW+1:DW-1] == '1), x[DW-1:0]};
    endfunction

    pe2_pair_fifo #(.T(pair_t), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        {ov[0], push_data.sum.re}  = scale(sum_q.re, scl_q);
        {ov[1], push_data.sum.im}  = scale(sum_q.im, scl_q);
        {ov[2], push_data.diff.re} = scale(diff_q.re, scl_q);
        {ov[3], push_data.diff.im} = scale(diff_q.im, scl_q);
        push    = bfly_v_q && !full;
        in_rdy  = select_i ? (count + CW'(bfly_v_q)) < CW'(DEPTH) : bus.out_ready;
        acc_in  = bus.in_valid && in_rdy;
        head_w  = out_phase_q == PH_DIFF ? head.diff : head.sum;
        bus.in_ready  = in_rdy;
        bus.out_valid = select_i ? !empty : bus.in_valid;
        bus.out_re    = select_i ? (empty ? '0 : head_w.re) : bus.in_re;
        bus.out_im    = select_i ? (empty ? '0 : head_w.im) : bus.in_im;
        acc_out = bus.out_valid && bus.out_ready;
        pop     = select_i && acc_out && out_phase_q == PH_DIFF;
        in_phase_d  = !select_i ? PH_UP : acc_in ? (in_phase_q == PH_UP ? PH_DOWN : PH_UP) : in_phase_q;
        out_phase_d = !select_i ? PH_SUM : acc_out ? (out_phase_q == PH_SUM ? PH_DIFF : PH_SUM) : out_phase_q;
        up_d     = select_i && acc_in && in_phase_q == PH_UP ? sample_t'{bus.in_re, bus.in_im} : up_q;
        bfly_v_d = select_i && acc_in && in_phase_q == PH_DOWN;
        sum_d.re  = bfly_v_d ? {up_q.re[DW-1], up_q.re} + {bus.in_re[DW-1], bus.in_re} : sum_q.re;
        sum_d.im  = bfly_v_d ? {up_q.im[DW-1], up_q.im} + {bus.in_im[DW-1], bus.in_im} : sum_q.im;
        diff_d.re = bfly_v_d ? {up_q.re[DW-1], up_q.re} - {bus.in_re[DW-1], bus.in_re} : diff_q.re;
        diff_d.im = bfly_v_d ? {up_q.im[DW-1], up_q.im} - {bus.in_im[DW-1], bus.in_im} : diff_q.im;
        scl_d    = bfly_v_d ? scaling_i : scl_q;
        ovf_d    = ovf_q || (push && |ov);
        ovf_o    = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_phase_q  <= PH_UP;
            out_phase_q <= PH_SUM;
            up_q        <= '0;
            sum_q       <= '0;
            diff_q      <= '0;
            bfly_v_q    <= 1'b0;
            scl_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            in_phase_q  <= in_phase_d;
            out_phase_q <= out_phase_d;
            up_q        <= up_d;
            sum_q       <= sum_d;
            diff_q      <= diff_d;
            bfly_v_q    <= bfly_v_d;
            scl_q       <= scl_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pe2_bfly_param.sv
// tb_pe2_bfly_param: directed vectors plus an integer-arithmetic output queue model for pe2_bfly_param.
module tb_pe2_bfly_param;
    import pe2_bfly_param_pkg::*;
    localparam int DW = 16, DEPTH = 8, SW = 2;
    logic          clk = 0;
    logic          rst_n = 0;
    logic          select = 1;
    logic [SW-1:0] scaling = 0;
    logic          ovf;
    int            checks = 0, errs = 0;

    pe2_bfly_param_if #(.DW(DW)) bus ();
    pe2_bfly_param #(.DW(DW), .DEPTH(DEPTH), .SCALE_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .select_i  (select),
        .scaling_i (scaling),
        .ovf_o     (ovf),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Model: expected output words in order, pairing phase, ovf delayed to FIFO write time.
    logic [31:0] q[$];
    int          m_up_re, m_up_im, m_pairs = 0;
    bit          m_phase, m_ovf, d0, d1;
    logic [16:0] sr, si, dr, di;

    function automatic logic [16:0] mscale(input int v, input int s);
        int r;
`ifdef PE2_ROUND_EN
        if (s > 0) v = v + (1 << (s - 1));
`endif
        r = v >>> s;
        return {r > 32767 || r < -32768, 16'(r)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_phase = 0;
            m_ovf = 0;
            d0 = 0;
            d1 = 0;
        end else begin
            m_ovf = m_ovf | d1;
            d1 = d0;
            d0 = 0;
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (select) begin
                if (bus.out_valid) begin
                    if (q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 0);
                    else begin
                        chk("out", {bus.out_re, bus.out_im}, q[0]);
                        if (bus.out_ready) void'(q.pop_front());
                    end
                end else chk("idle_out", {bus.out_re, bus.out_im}, 0);
                if (bus.in_valid && bus.in_ready) begin
                    if (!m_phase) begin
                        m_up_re = bus.in_re;
                        m_up_im = bus.in_im;
                    end else begin
                        sr = mscale(m_up_re + bus.in_re, int'(scaling));
                        si = mscale(m_up_im + bus.in_im, int'(scaling));
                        dr = mscale(m_up_re - bus.in_re, int'(scaling));
                        di = mscale(m_up_im - bus.in_im, int'(scaling));
                        q.push_back({sr[15:0], si[15:0]});
                        q.push_back({dr[15:0], di[15:0]});
                        d0 = sr[16] | si[16] | dr[16] | di[16];
                        m_pairs++;
                    end
                    m_phase = !m_phase;
                end
            end else begin
                m_phase = 0;
                chk("byp_valid", 32'(bus.out_valid), 32'(bus.in_valid));
                chk("byp_data", {bus.out_re, bus.out_im}, {bus.in_re, bus.in_im});
                chk("byp_ready", 32'(bus.in_ready), 32'(bus.out_ready));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im);
        bus.in_valid = 1;
        bus.in_re = 16'(re);
        bus.in_im = 16'(im);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                bus.in_valid = 0;
                return;
            end
        end
        chk("send_timeout", 32'(bus.in_ready), 1);
        bus.in_valid = 0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] exp);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk(name, {bus.out_re, bus.out_im}, exp);
                return;
            end
        end
        chk({name, "_timeout"}, 32'(bus.out_valid), 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        int p0;
        bus.in_valid = 0;
        bus.in_re = 0;
        bus.in_im = 0;
        bus.out_ready = 1;
        repeat (2) step();
        rst_n = 1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_ovf", 32'(ovf), 0);
        step();
        // basic butterfly and two-cycle latency
        send(3, 1);
        send(1, 2);
        @(negedge clk);
        chk("t1_lat_t0", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("t1_lat_t1", 32'(bus.out_valid), 1);
        chk("t1_sum", {bus.out_re, bus.out_im}, 32'h0004_0003);
        expect_out("t1_diff", 32'h0002_ffff);
        step();
        // scaling by one
        scaling = 1;
        send(5, 0);
        send(2, 0);
`ifdef PE2_ROUND_EN
        expect_out("t2_sum", 32'h0004_0000);
        expect_out("t2_diff", 32'h0002_0000);
`else
        expect_out("t2_sum", 32'h0003_0000);
        expect_out("t2_diff", 32'h0001_0000);
`endif
        step();
        scaling = 0;
        // backpressure: exactly DEPTH pairs buffered, then full drain in order
        bus.out_ready = 0;
        p0 = m_pairs;
        fork
            for (int i = 0; i < 2 * DEPTH; i++) begin
                send(i, -i);
                send(2 * i + 1, 3);
            end
            begin
                repeat (60) @(negedge clk);
                chk("t3_stall_ready", 32'(bus.in_ready), 0);
                chk("t3_pairs", 32'(m_pairs - p0), DEPTH);
                chk("t3_first", {bus.out_re, bus.out_im}, 32'h0001_0003);
                step();
                bus.out_ready = 1;
            end
        join
        for (int n = 0; n < 200 && (q.size() != 0 || bus.out_valid); n++) @(negedge clk);
        chk("t3_drain", 32'(q.size()), 0);
        step();
        // overflow on wrap, sticky until reset; scaling avoids it
        do_reset();
        send(32767, 0);
        send(1, 0);
        expect_out("t4_sum", 32'h8000_0000);
        expect_out("t4_diff", 32'h7ffe_0000);
        chk("t4_ovf", 32'(ovf), 1);
        repeat (5) @(negedge clk);
        chk("t4_ovf_sticky", 32'(ovf), 1);
        step();
        do_reset();
        @(negedge clk);
        chk("t4_ovf_clr", 32'(ovf), 0);
        step();
        scaling = 1;
        send(32767, 0);
        send(1, 0);
        expect_out("t4s_sum", 32'h4000_0000);
        expect_out("t4s_diff", 32'h3fff_0000);
        chk("t4s_ovf", 32'(ovf), 0);
        step();
        scaling = 0;
        // bypass
        select = 0;
        bus.in_valid = 1;
        bus.in_re = 123;
        bus.in_im = -45;
        bus.out_ready = 0;
        #1;
        chk("t5_ready_lo", 32'(bus.in_ready), 0);
        chk("t5_valid", 32'(bus.out_valid), 1);
        chk("t5_out", {bus.out_re, bus.out_im}, 32'h007b_ffd3);
        bus.out_ready = 1;
        #1;
        chk("t5_ready_hi", 32'(bus.in_ready), 1);
        repeat (3) @(negedge clk);
        step();
        bus.in_valid = 0;
        select = 1;
        #1;
        chk("t5_fifo_untouched", 32'(bus.out_valid), 0);
        step();
        // reset with three pairs buffered and an up sample held
        bus.out_ready = 0;
        send(1, 1); send(2, 2);
        send(3, 3); send(4, 4);
        send(5, 5); send(6, 6);
        send(7, 7);
        repeat (3) @(negedge clk);
        chk("t6_buffered", 32'(bus.out_valid), 1);
        step();
        do_reset();
        @(negedge clk);
        chk("t6_valid", 32'(bus.out_valid), 0);
        chk("t6_ready", 32'(bus.in_ready), 1);
        step();
        bus.out_ready = 1;
        send(10, 1);
        send(4, 2);
        expect_out("t6_sum", 32'h000e_0003);
        expect_out("t6_diff", 32'h0006_ffff);
        repeat (3) @(negedge clk);
        chk("end_drain", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
